// File: rtl/parking_occupancy_ctrl_if.sv
// Sensor/status bundle between the lot sensors, the occupancy controller and the display/gate side.
// master: sensor side (drives car_in/car_out, observes status); slave: the occupancy controller.
// Macro PARK_STATS_EN adds the 16-bit total_entries/total_rejects statistics signals.
interface parking_occupancy_ctrl_if #(
  parameter int CNT_W = 4
);
  logic             car_in;
  logic             car_out;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] free;
  logic             full;
  logic             empty;
  logic             gate_in;
  logic             gate_out;
  logic             reject;
  logic             underflow;
`ifdef PARK_STATS_EN
  logic [15:0]      total_entries;
  logic [15:0]      total_rejects;

  modport master (
    output car_in, car_out,
    input  count, free, full, empty, gate_in, gate_out, reject, underflow,
    input  total_entries, total_rejects
  );
  modport slave (
    input  car_in, car_out,
    output count, free, full, empty, gate_in, gate_out, reject, underflow,
    output total_entries, total_rejects
  );
`else
  modport master (
    output car_in, car_out,
    input  count, free, full, empty, gate_in, gate_out, reject, underflow
  );
  modport slave (
    input  car_in, car_out,
    output count, free, full, empty, gate_in, gate_out, reject, underflow
  );
`endif
endinterface

// File: rtl/parking_occupancy_ctrl.sv
// Parking lot occupancy tracker: sensor edges -> add/subtract count, gate-open pulses, full/empty.
// Latency 1 cycle from sensor edge to count/flags/pulses/gate; no backpressure, every edge is handled.
// Macro PARK_STATS_EN adds saturating total_entries/total_rejects counters.
module parking_occupancy_ctrl #(
  parameter int CAPACITY    = 8,
  parameter int CNT_W       = 4,
  parameter int GATE_CYCLES = 4
) (
  input logic                    clk,
  input logic                    rst,
  parking_occupancy_ctrl_if.slave bus
);

  localparam int               GW        = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CAP       = CNT_W'(CAPACITY);
  localparam logic [GW-1:0]    GATE_LOAD = GW'(GATE_CYCLES - 1);

  typedef enum logic {CLOSED, OPEN} gate_state_t;

  logic             car_in_q, car_out_q;
  logic             in_ev, out_ev, acc_in, acc_out;
  logic [CNT_W-1:0] count_q, count_d;
  logic             reject_q, underflow_q;
  logic [1:0]       gate_ev;   // [0] entry gate, [1] exit gate
  gate_state_t      gate_q [2];
  gate_state_t      gate_d [2];
  logic [GW-1:0]    gcnt_q [2];
  logic [GW-1:0]    gcnt_d [2];

  // Edge detect and accept/refuse decision; a simultaneous exit always makes room for the entry.
  always_comb begin
    in_ev   = bus.car_in & ~car_in_q;
    out_ev  = bus.car_out & ~car_out_q;
    acc_out = out_ev & (count_q != '0);
    acc_in  = in_ev & ((count_q < CAP) | out_ev);
    count_d = count_q;
    if (acc_in && !acc_out) begin
      count_d = count_q + CNT_W'(1);
    end else if (acc_out && !acc_in) begin
      count_d = count_q - CNT_W'(1);
    end
    gate_ev = {acc_out, acc_in};
  end

  // Occupancy count, sensor history and one-cycle error pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      car_in_q    <= 1'b0;
      car_out_q   <= 1'b0;
      count_q     <= '0;
      reject_q    <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      car_in_q    <= bus.car_in;
      car_out_q   <= bus.car_out;
      count_q     <= count_d;
      reject_q    <= in_ev & ~acc_in;
      underflow_q <= out_ev & ~acc_out;
    end
  end

  // Gate FSM next state: an accepted event (re)loads the hold counter, otherwise count down to close.
  always_comb begin
    for (int g = 0; g < 2; g++) begin
      gate_d[g] = gate_q[g];
      gcnt_d[g] = gcnt_q[g];
      if (gate_ev[g]) begin
        gate_d[g] = OPEN;
        gcnt_d[g] = GATE_LOAD;
      end else if (gate_q[g] == OPEN) begin
        if (gcnt_q[g] == '0) begin
          gate_d[g] = CLOSED;
        end else begin
          gcnt_d[g] = gcnt_q[g] - GW'(1);
        end
      end
    end
  end

  // Gate FSM state registers.
  always_ff @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (rst) begin
        gate_q[g] <= CLOSED;
        gcnt_q[g] <= '0;
      end else begin
        gate_q[g] <= gate_d[g];
        gcnt_q[g] <= gcnt_d[g];
      end
    end
  end

  assign bus.count     = count_q;
  assign bus.free      = CAP - count_q;
  assign bus.full      = (count_q == CAP);
  assign bus.empty     = (count_q == '0);
  assign bus.gate_in   = (gate_q[0] == OPEN);
  assign bus.gate_out  = (gate_q[1] == OPEN);
  assign bus.reject    = reject_q;
  assign bus.underflow = underflow_q;

`ifdef PARK_STATS_EN
  logic [15:0] tot_ent_q, tot_rej_q;

  // Saturating lifetime counters of accepted and refused entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      tot_ent_q <= '0;
      tot_rej_q <= '0;
    end else begin
      if (acc_in && tot_ent_q != 16'hFFFF) tot_ent_q <= tot_ent_q + 16'd1;
      if (in_ev && !acc_in && tot_rej_q != 16'hFFFF) tot_rej_q <= tot_rej_q + 16'd1;
    end
  end

  assign bus.total_entries = tot_ent_q;
  assign bus.total_rejects = tot_rej_q;
`endif

endmodule

// File: tb/tb_parking_occupancy_ctrl.sv
// Self-checking bench for parking_occupancy_ctrl: directed test-plan scenarios plus random sensor traffic.
// Every cycle all outputs are compared on the falling edge against a behavioural lot model.
// Compiles with or without PARK_STATS_EN.
module tb_parking_occupancy_ctrl;
  localparam int CAPACITY    = 8;
  localparam int CNT_W       = 4;
  localparam int GATE_CYCLES = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  parking_occupancy_ctrl_if #(.CNT_W(CNT_W)) bus ();

  parking_occupancy_ctrl #(
    .CAPACITY(CAPACITY), .CNT_W(CNT_W), .GATE_CYCLES(GATE_CYCLES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: cars parked, remaining open cycles per gate, pending pulses.
  int m_count, m_in_left, m_out_left, m_tot_ent, m_tot_rej;
  bit m_rej, m_unf, m_prev_in, m_prev_out;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge(input bit r, input bit ci, input bit co);
    bit ie, oe, ai, ao;
    if (r) begin
      m_count = 0; m_in_left = 0; m_out_left = 0;
      m_rej = 0; m_unf = 0; m_prev_in = 0; m_prev_out = 0;
      m_tot_ent = 0; m_tot_rej = 0;
      return;
    end
    ie = ci && !m_prev_in;
    oe = co && !m_prev_out;
    ai = 0; ao = 0;
    if (ie && oe) begin
      ai = 1;                  // the leaving car (if any) frees a space
      ao = (m_count > 0);
    end else if (ie) begin
      ai = (m_count < CAPACITY);
    end else if (oe) begin
      ao = (m_count > 0);
    end
    m_count = m_count + int'(ai) - int'(ao);
    m_rej = ie && !ai;
    m_unf = oe && !ao;
    if (ai) m_in_left = GATE_CYCLES; else if (m_in_left > 0) m_in_left--;
    if (ao) m_out_left = GATE_CYCLES; else if (m_out_left > 0) m_out_left--;
    if (ai && m_tot_ent < 65535) m_tot_ent++;
    if (m_rej && m_tot_rej < 65535) m_tot_rej++;
    m_prev_in = ci;
    m_prev_out = co;
  endtask

  task automatic check_all();
    check("count", bus.count, m_count);
    check("free", bus.free, CAPACITY - m_count);
    check("full", bus.full, m_count == CAPACITY);
    check("empty", bus.empty, m_count == 0);
    check("gate_in", bus.gate_in, m_in_left > 0);
    check("gate_out", bus.gate_out, m_out_left > 0);
    check("reject", bus.reject, m_rej);
    check("underflow", bus.underflow, m_unf);
`ifdef PARK_STATS_EN
    check("total_entries", bus.total_entries, m_tot_ent);
    check("total_rejects", bus.total_rejects, m_tot_rej);
`endif
  endtask

  // Drive one cycle of inputs, let the edge happen, then compare on the falling edge.
  task automatic step(input bit r, input bit ci, input bit co);
    rst = r;
    bus.car_in = ci;
    bus.car_out = co;
    @(posedge clk);
    model_edge(r, ci, co);
    @(negedge clk);
    check_all();
  endtask

  task automatic pulse_in();
    step(0, 1, 0);
    repeat (5) step(0, 0, 0);
  endtask

  initial begin
    bit ci, co, r;
    ci = 0; co = 0;
    model_edge(1, 0, 0);

    // reset with idle sensors
    step(1, 0, 0);
    step(1, 0, 0);
    check("reset_free", bus.free, 8);

    // three separate entries, then a held level that counts once
    repeat (3) pulse_in();
    check("three_entries", bus.count, 3);
    repeat (10) step(0, 1, 0);
    repeat (5) step(0, 0, 0);
    check("held_level_once", bus.count, 4);

    // fill the lot, then one more entry is refused
    repeat (4) pulse_in();
    check("filled", bus.count, 8);
    step(0, 1, 0);
    check("reject_pulse", bus.reject, 1);
    check("reject_gate_closed", bus.gate_in, 0);
    repeat (5) step(0, 0, 0);

    // simultaneous entry and exit while full
    step(0, 1, 1);
    check("swap_gate_in", bus.gate_in, 1);
    check("swap_gate_out", bus.gate_out, 1);
    repeat (5) step(0, 0, 0);
    check("swap_count", bus.count, 8);

    // underflow from empty
    step(1, 0, 0);
    step(0, 0, 1);
    check("underflow_pulse", bus.underflow, 1);
    repeat (3) step(0, 0, 0);

    // second entry while the gate is still open extends it
    step(0, 1, 0);
    step(0, 0, 0);
    step(0, 1, 0);
    repeat (6) step(0, 0, 0);

    // reset at count 5 with the entry gate open
    repeat (2) pulse_in();
    step(0, 1, 0);
    check("pre_reset_count", bus.count, 5);
    step(1, 0, 0);
    check("post_reset_count", bus.count, 0);

    // random traffic: entry-heavy first half, exit-heavy second half
    for (int i = 0; i < 4000; i++) begin
      int pin, pout;
      pin  = (i < 2000) ? 2 : 5;
      pout = (i < 2000) ? 5 : 2;
      if ($urandom_range(0, pin) == 0) ci = ~ci;
      if ($urandom_range(0, pout) == 0) co = ~co;
      r = ($urandom_range(0, 299) == 0);
      step(r, ci, co);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
